mp_add_sequencer: RTL and testbench
===================================

# mp_add_sequencer

Multi-precision add sequencer: serves two requesters over one 64-bit add slice, computing `64*CHUNKS`-bit sums one 64-bit chunk per cycle with the carry chained between chunks. It arbitrates round-robin, latches operands, runs the chunk loop and holds the result behind a valid/ready response port. It sits between the wide-integer clients and the shared 64-bit adder datapath.

## Interface
- `CHUNKS`, default 4: number of 64-bit chunks per operand; operand width `W = 64*CHUNKS`; legal range ≥ 1.
- `clk`  in  1  — single clock, all state on rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `req0_valid`  in  1  — requester 0 has an operation.
- `req0_ready`  out  1  — requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  W  — requester 0 operands.
- `req0_cin`  in  1  — requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  — result available.
- `rsp_ready`  in  1  — consumer takes result.
- `rsp_id`  out  1  — requester index of the result.
- `rsp_sum`  out  W  — `(a + b + cin) mod 2^W`.
- `rsp_cout`  out  1  — carry out of the top chunk.
- `busy`  out  1  — high in RUN and DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE, arbitration:**
  - Only one valid: grant it.
  - Both valid: grant the one not in `last_grant`.
  - Neither valid: stay in IDLE.
- **IDLE, on grant:**
  - `reqN_ready` = 1 combinationally for the granted requester only; it may depend on `reqN_valid`.
  - Latch `a`, `b` and `id`; `carry <= cin`; `k <= 0`; go to RUN.
- **RUN, each cycle:**
  - Slice computes chunk `k`.
    - Low 32 bits use `carry` as carry-in.
    - High 32 bits use the low-half carry-out.
  - Write result to `sum[64k +: 64]`; `carry <=` high-half carry-out; `k <= k+1`.
  - After chunk `CHUNKS-1`, go to DONE with `rsp_cout = carry`.
- **DONE:**
  - `rsp_valid` = 1; `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid & rsp_ready`.
  - On that handshake: `last_grant <= rsp_id`, go to IDLE.
- **`reqN_ready`:** always 0 outside IDLE. A new request is never accepted in the DONE handshake cycle.
- **Arithmetic:** wrap-around modulo `2^W`; overflow reported only via `rsp_cout`. No sign handling.
- **Reset values:**
  - `rsp_valid`, `rsp_sum`, `rsp_cout`, `rsp_id`, `busy`, `req*_ready` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - State = IDLE, `k` = 0, `carry` = 0.
- **Reset mid-operation:** the in-flight operation is dropped with no response; all outputs return to reset values immediately (asynchronous).
- **Requester obligations:** operands must be stable while valid; the sequencer samples them only in the accept cycle.

## Timing
- Accept at edge T (valid & ready in cycle T).
- RUN occupies cycles T+1 … T+CHUNKS; `rsp_valid` rises in cycle T+CHUNKS+1.
- Latency with `rsp_ready` held high: `CHUNKS+1` cycles from accept to response.
- Minimum spacing between accepts: `CHUNKS+2` cycles.
- Arbitration and ready generation are combinational in IDLE.
- The chunk adder is a single-cycle combinational path of 64 bits with ripple between halves; no state-to-output combinational paths except `req*_ready`.

## Structure
- **Shared package:**
  - `CHUNK_W` = 64, `HALF_W` = 32.
  - State enum `{IDLE, RUN, DONE}`.
  - Chunk-index width function `clog2(CHUNKS)`, minimum 1.
- **Sub-module `add64_slice`:** combinational 64-bit adder built from two 32-bit halves.
  - Inputs: `cin`.
  - Outputs: `cout_lo` (inter-half carry) and `cout_hi`.
  - Instantiated once; all sequencing, arbitration and storage stay in `mp_add_sequencer`.

## Test plan
- Use `CHUNKS` = 4 unless a scenario states otherwise.
- **Full carry ripple:** after reset, req0 with a=1, b=all-ones (256 b), cin=0 → `rsp_sum`=0, `rsp_cout`=1, `rsp_id`=0, `rsp_valid` 5 cycles after accept.
- **Half boundary:** req1 with a=0x00000000_FFFFFFFF, b=1 → chunk0 = 0x00000001_00000000, upper chunks 0, cout=0.
- **Carry-in only:** a=b=0, cin=1 → sum=1, cout=0.
- **Arbitration fairness:** req0 and req1 held valid for 4 operations with `rsp_ready`=1 → grant order 0,1,0,1; accepts 6 cycles apart.
- **Backpressure:** `rsp_ready`=0 for 10 cycles in DONE → `rsp_valid`/`sum`/`id` stable, `req*_ready`=0, `busy`=1; release → IDLE next cycle.
- **Reset mid-RUN:** assert `resetn`=0 at k=2 → all outputs 0 immediately; after release, req0 a=5, b=7 → sum=12 with normal latency.

Source files
------------

// File: rtl/mp_add_sequencer_pkg.sv
// Shared constants, FSM state type and index-width helper for the multi-precision add sequencer.
package mp_add_sequencer_pkg;

   localparam int CHUNK_W = 64;
   localparam int HALF_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_w(input int chunks);
      return (chunks <= 1) ? 1 : $clog2(chunks);
   endfunction

endpackage

// File: rtl/add64_slice.sv
// Combinational 64-bit adder made of two 32-bit halves; the low-half carry ripples into the high half.
module add64_slice
   import mp_add_sequencer_pkg::*;
(
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic               cin,
   output logic [CHUNK_W-1:0] sum,
   output logic               cout_lo,
   output logic               cout_hi
);

   logic [HALF_W:0] lo;
   logic [HALF_W:0] hi;

   assign lo = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]} + {{HALF_W{1'b0}}, cin};
   assign hi = {1'b0, a[CHUNK_W-1:HALF_W]} + {1'b0, b[CHUNK_W-1:HALF_W]} + {{HALF_W{1'b0}}, lo[HALF_W]};

   assign sum     = {hi[HALF_W-1:0], lo[HALF_W-1:0]};
   assign cout_lo = lo[HALF_W];
   assign cout_hi = hi[HALF_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Two-requester round-robin sequencer that adds 64*CHUNKS-bit operands one 64-bit chunk per cycle.
// Handshakes: a transfer happens on a rising edge where both valid and ready are high.
module mp_add_sequencer
   import mp_add_sequencer_pkg::*;
#(
   parameter int CHUNKS = 4
)(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [CHUNK_W*CHUNKS-1:0] req0_a,
   input  logic [CHUNK_W*CHUNKS-1:0] req0_b,
   input  logic                      req0_cin,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [CHUNK_W*CHUNKS-1:0] req1_a,
   input  logic [CHUNK_W*CHUNKS-1:0] req1_b,
   input  logic                      req1_cin,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_id,
   output logic [CHUNK_W*CHUNKS-1:0] rsp_sum,
   output logic                      rsp_cout,
   output logic                      busy,
   output state_t                    dbg_state
);

   localparam int W  = CHUNK_W * CHUNKS;
   localparam int KW = idx_w(CHUNKS);
   localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

   state_t          state;
   logic [KW-1:0]   k;
   logic            carry;
   logic            last_grant;
   logic            id_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    sum_q;
   logic            gnt0;
   logic            gnt1;
   logic [CHUNK_W-1:0] chunk_a;
   logic [CHUNK_W-1:0] chunk_b;
   logic [CHUNK_W-1:0] chunk_sum;
   logic            chunk_cout_lo;
   logic            chunk_cout_hi;

   // Tie goes to the requester that was not served last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && resetn) begin
         if (req0_valid && (!req1_valid || last_grant)) begin
            gnt0 = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign chunk_a = a_q[CHUNK_W*k +: CHUNK_W];
   assign chunk_b = b_q[CHUNK_W*k +: CHUNK_W];

   add64_slice u_slice (
      .a       (chunk_a),
      .b       (chunk_b),
      .cin     (carry),
      .sum     (chunk_sum),
      .cout_lo (chunk_cout_lo),
      .cout_hi (chunk_cout_hi)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         k          <= '0;
         carry      <= 1'b0;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_cout   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_q   <= gnt1 ? req1_a   : req0_a;
                  b_q   <= gnt1 ? req1_b   : req0_b;
                  carry <= gnt1 ? req1_cin : req0_cin;
                  id_q  <= gnt1;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_q[CHUNK_W*k +: CHUNK_W] <= chunk_sum;
               carry <= chunk_cout_hi;
               if (k == K_LAST) begin
                  k         <= '0;
                  rsp_cout  <= chunk_cout_hi;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  last_grant <= id_q;
                  rsp_valid  <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: directed vector table, corner-case sequences and random ops.
module tb_mp_add_sequencer;
   import mp_add_sequencer_pkg::*;

   localparam int CHUNKS = 4;
   localparam int W      = CHUNK_W * CHUNKS;
   localparam int LAT    = CHUNKS + 1;

   logic         clk;
   logic         resetn;
   logic         req0_valid, req0_ready, req0_cin;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [W-1:0] rsp_sum;
   state_t       dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_id_q[$];

   mp_add_sequencer #(.CHUNKS(CHUNKS)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // scoreboard helpers
   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h required %0h", name, got, exp);
      else n_pass++;
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom();
      return v;
   endfunction

   // driver tasks
   task automatic clear_reqs();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
   endtask

   task automatic drive_req(input logic port, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      if (port) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_reqs();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // One operation with rsp_ready held high; lat counts cycles from the accept cycle to rsp_valid.
   task automatic do_op(input logic port, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic co, output logic id, output int lat);
      int t;
      s = '0; co = 1'b0; id = 1'b0; lat = -1;
      @(negedge clk);
      drive_req(port, a, b, cin);
      rsp_ready = 1'b1;
      #1;
      t = 0;
      while (!(port ? req1_ready : req0_ready) && t < 20) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 20) begin
         check("accept_timeout", 1'b0, 1'b1);
         clear_reqs();
         return;
      end
      @(posedge clk); #1;
      clear_reqs();
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
      s = rsp_sum; co = rsp_cout; id = rsp_id;
   endtask

   typedef struct {
      logic         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [W-1:0] s;
      logic [W-1:0] ones;
      logic [W-1:0] top;
      logic [W:0]   m;
      logic         co, id;
      int           lat, n_acc, n_rsp, t;
      int           acc_cyc[$];
      logic         acc_id[$];
      logic [W-1:0] a0, b0, a1, b1;

      ones = '1;
      top  = '0;
      top[W-1] = 1'b1;

      vecs[0] = '{1'b0, W'(1),             ones, 1'b0, '0,                    1'b1};
      vecs[1] = '{1'b1, W'(64'hFFFF_FFFF), W'(1), 1'b0, W'(64'h1_0000_0000),  1'b0};
      vecs[2] = '{1'b0, '0,                '0,    1'b1, W'(1),                1'b0};
      vecs[3] = '{1'b1, ones,              '0,    1'b1, '0,                   1'b1};
      vecs[4] = '{1'b0, ones,              ones,  1'b1, ones,                 1'b1};
      vecs[5] = '{1'b1, top,               top,   1'b0, '0,                   1'b1};

      // reset state, with both requests pending to show ready stays low in reset
      clear_reqs();
      rsp_ready = 1'b0;
      resetn = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_sum", rsp_sum, '0);
      check("rst_rsp_cout", rsp_cout, 1'b0);
      check("rst_rsp_id", rsp_id, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_req0_ready", req0_ready, 1'b0);
      check("rst_req1_ready", req1_ready, 1'b0);
      check("rst_state", dbg_state, IDLE);
      clear_reqs();
      @(negedge clk);
      resetn = 1'b1;

      // directed vector table
      foreach (vecs[i]) begin
         do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, id, lat);
         check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
         check($sformatf("vec%0d_cout", i), co, vecs[i].exp_cout);
         check($sformatf("vec%0d_id", i), id, vecs[i].port);
         check($sformatf("vec%0d_lat", i), W'(lat), W'(LAT));
      end

      // fairness: both held valid after reset, grants must alternate starting at 0
      do_reset();
      a0 = rand_wide(); b0 = rand_wide();
      a1 = rand_wide(); b1 = rand_wide();
      @(negedge clk);
      drive_req(1'b0, a0, b0, 1'b0);
      drive_req(1'b1, a1, b1, 1'b1);
      rsp_ready = 1'b1;
      n_acc = 0; n_rsp = 0; t = 0;
      #1;
      while ((n_acc < 4 || n_rsp < 4) && t < 60) begin
         if (req0_ready && req1_ready) check("dual_ready", 1'b1, 1'b0);
         if (rsp_valid) begin
            n_rsp++;
            if (exp_q.size() > 0) begin
               check("fair_rsp_sum", rsp_sum, exp_q.pop_front());
               check("fair_rsp_id", rsp_id, exp_id_q.pop_front());
            end else begin
               check("fair_unexpected_rsp", 1'b1, 1'b0);
            end
         end
         if (req0_ready || req1_ready) begin
            n_acc++;
            acc_cyc.push_back(cyc);
            acc_id.push_back(req1_ready);
            m = req1_ready ? model(a1, b1, 1'b1) : model(a0, b0, 1'b0);
            exp_q.push_back(m[W-1:0]);
            exp_id_q.push_back(req1_ready);
         end
         @(negedge clk);
         if (n_acc == 4) clear_reqs();
         #1;
         t++;
      end
      check("fair_accepts", W'(n_acc), W'(4));
      check("fair_rsps", W'(n_rsp), W'(4));
      if (acc_id.size() == 4) begin
         check("fair_grant0", acc_id[0], 1'b0);
         check("fair_grant1", acc_id[1], 1'b1);
         check("fair_grant2", acc_id[2], 1'b0);
         check("fair_grant3", acc_id[3], 1'b1);
         for (int i = 1; i < 4; i++)
            check($sformatf("fair_gap%0d", i), W'(acc_cyc[i] - acc_cyc[i-1]), W'(CHUNKS + 2));
      end
      exp_q.delete();
      exp_id_q.delete();

      // backpressure: hold the result for 10 cycles with requests pending
      @(negedge clk);
      a0 = rand_wide(); b0 = rand_wide();
      drive_req(1'b1, a0, b0, 1'b0);
      rsp_ready = 1'b0;
      m = model(a0, b0, 1'b0);
      #1;
      t = 0;
      while (!req1_ready && t < 20) begin @(negedge clk); #1; t++; end
      check("bp_accept", req1_ready, 1'b1);
      @(posedge clk); #1;
      clear_reqs();
      t = 0;
      while (!rsp_valid && t < 50) begin @(negedge clk); #1; t++; end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_sum", rsp_sum, m[W-1:0]);
         check("bp_cout", rsp_cout, m[W]);
         check("bp_id", rsp_id, 1'b1);
         check("bp_req0_ready", req0_ready, 1'b0);
         check("bp_req1_ready", req1_ready, 1'b0);
         check("bp_busy", busy, 1'b1);
         @(negedge clk); #1;
      end
      clear_reqs();
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      check("bp_release_state", dbg_state, IDLE);
      check("bp_release_valid", rsp_valid, 1'b0);
      check("bp_release_busy", busy, 1'b0);

      // reset in the middle of RUN, at chunk 2
      @(negedge clk);
      drive_req(1'b0, rand_wide(), rand_wide(), 1'b1);
      #1;
      t = 0;
      while (!req0_ready && t < 20) begin @(negedge clk); #1; t++; end
      @(posedge clk); #1;
      clear_reqs();
      repeat (3) @(negedge clk);
      #1;
      check("mid_state_run", dbg_state, RUN);
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_sum", rsp_sum, '0);
      check("mid_rst_cout", rsp_cout, 1'b0);
      check("mid_rst_id", rsp_id, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_state", dbg_state, IDLE);
      @(negedge clk);
      resetn = 1'b1;
      do_op(1'b0, W'(5), W'(7), 1'b0, s, co, id, lat);
      check("post_rst_sum", s, W'(12));
      check("post_rst_cout", co, 1'b0);
      check("post_rst_id", id, 1'b0);
      check("post_rst_lat", W'(lat), W'(LAT));

      // random operations against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         logic         p, c;
         logic [W-1:0] ra, rb;
         p  = 1'($urandom_range(0, 1));
         c  = 1'($urandom_range(0, 1));
         ra = rand_wide();
         rb = rand_wide();
         if ($urandom_range(0, 3) == 0) rb = ~ra;
         m = model(ra, rb, c);
         exp_q.push_back(m[W-1:0]);
         do_op(p, ra, rb, c, s, co, id, lat);
         check("rnd_sum", s, exp_q.pop_front());
         check("rnd_cout", co, m[W]);
         check("rnd_id", id, p);
         check("rnd_lat", W'(lat), W'(LAT));
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
